// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO, 2**ADDR_W usable words, with occupancy,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Optional feature macro: FIFO_LEVEL_FWFT_EN
//   defined   -> first-word-fall-through read port (r_data = head word)
//   undefined -> registered read port (r_data loads on accepted read)
//
// Parameters:
//   WORD_LEN  data width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   AF_TH     almost_full  when count >= AF_TH
//   AE_TH     almost_empty when count <= AE_TH
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous reset, active-low
//   rd / wr       pop / push requests
//   w_data        write data
//   clr_err       clears overflow/underflow (a new error wins)
//   r_data        read data
//   empty, full, almost_empty, almost_full   status from count
//   count         occupancy 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
module fifo_level #(
    parameter int WORD_LEN = 8,
    parameter int ADDR_W   = 8,
    parameter int AF_TH    = 2**ADDR_W - 4,
    parameter int AE_TH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [WORD_LEN-1:0] w_data,
    input  logic                clr_err,
    output logic [WORD_LEN-1:0] r_data,
    output logic                empty,
    output logic                full,
    output logic                almost_empty,
    output logic                almost_full,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_TH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_TH);

    logic [WORD_LEN-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic wa;
    logic ra;

    // Status is decoded from the registered count only, so it is
    // glitch-free and never depends on pointer comparison.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == DEPTH_C);
        almost_empty = (count_q <= AE_C);
        almost_full  = (count_q >= AF_C);
        count        = count_q;
        overflow     = ovf_q;
        underflow    = unf_q;
    end

    // A read at full frees a slot in the same edge, so the write
    // may be accepted alongside it.
    always_comb begin
        wa = wr & (~full | rd);
        ra = rd & ~empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wa) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (ra) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case (1'b1)
            wa & ~ra: count_d = count_q + 1'b1;
            ra & ~wa: count_d = count_q - 1'b1;
            default:  count_d = count_q;
        endcase
    end

    // Set wins over clear when both happen in the same cycle.
    always_comb begin
        ovf_d = (wr & ~wa) | (ovf_q & ~clr_err);
        unf_d = (rd & ~ra) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; a write is suppressed while reset is low.
    always_ff @(posedge clk) begin
        if (reset && wa) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

`ifdef FIFO_LEVEL_FWFT_EN

    // Head word is shown directly; zero while nothing is queued.
    always_comb begin
        if (empty) begin
            r_data = '0;
        end else begin
            r_data = mem_q[rd_ptr_q];
        end
    end

`else

    logic [WORD_LEN-1:0] r_data_q, r_data_d;

    // Head is captured at the accepting edge; with rd+wr at count 1
    // this is the old head, since the new word lands at wr_ptr.
    always_comb begin
        r_data_d = r_data_q;
        if (ra) begin
            r_data_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= r_data_d;
        end
    end

    assign r_data = r_data_q;

`endif

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_fifo_level;

    localparam int WL    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int AET   = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd;
    logic          wr;
    logic [WL-1:0] w_data;
    logic          clr_err;
    logic [WL-1:0] r_data;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    fifo_level #(
        .WORD_LEN(WL),
        .ADDR_W  (AW),
        .AF_TH   (AFT),
        .AE_TH   (AET)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd          (rd),
        .wr          (wr),
        .w_data      (w_data),
        .clr_err     (clr_err),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference model: a plain queue of words plus two sticky bits.
    byte unsigned mq[$];
    bit           m_ovf;
    bit           m_unf;
    logic [WL-1:0] m_rdata;
    bit           m_live = 1'b0;
    bit           m_wa;
    bit           m_ra;
    int           m_n;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_rdata = '0;
            m_live  = 1'b1;
        end else begin
            m_n  = mq.size();
            m_wa = wr && (m_n < DEPTH || rd);
            m_ra = rd && (m_n > 0);
            if (m_ra) m_rdata = mq.pop_front();
            if (m_wa) mq.push_back(w_data);
            m_ovf = (wr && !m_wa) || (m_ovf && !clr_err);
            m_unf = (rd && !m_ra) || (m_unf && !clr_err);
        end
    end

    function automatic logic [WL-1:0] exp_rdata();
`ifdef FIFO_LEVEL_FWFT_EN
        return (mq.size() > 0) ? WL'(mq[0]) : '0;
`else
        return m_rdata;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            chk("count", 32'(count), mq.size());
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("almost_empty", 32'(almost_empty),
                32'(mq.size() <= AET));
            chk("almost_full", 32'(almost_full),
                32'(mq.size() >= AFT));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("r_data", 32'(r_data), 32'(exp_rdata()));
        end
    end

    task automatic step(input bit r, input bit w,
                        input logic [WL-1:0] d, input bit c);
        rd      = r;
        wr      = w;
        w_data  = d;
        clr_err = c;
        @(posedge clk);
        #1;
        rd      = 1'b0;
        wr      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic pop(output logic [WL-1:0] d);
`ifdef FIFO_LEVEL_FWFT_EN
        d = r_data;
        step(1'b1, 1'b0, '0, 1'b0);
`else
        step(1'b1, 1'b0, '0, 1'b0);
        d = r_data;
`endif
    endtask

    task automatic pushpop(input logic [WL-1:0] wd,
                           output logic [WL-1:0] d);
`ifdef FIFO_LEVEL_FWFT_EN
        d = r_data;
        step(1'b1, 1'b1, wd, 1'b0);
`else
        step(1'b1, 1'b1, wd, 1'b0);
        d = r_data;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
    endtask

    logic [WL-1:0] d;
    int            wprob;

    initial begin
        reset   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        clr_err = 1'b0;
        w_data  = '0;
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;

        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_rdata", 32'(r_data), 0);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, WL'(i), 1'b0);
            chk("fill_count", 32'(count), i);
            chk("fill_ae", 32'(almost_empty), 32'(i < 2));
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 0);

        step(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);
        for (int i = 1; i <= 8; i++) begin
            pop(d);
            chk("drain_data", 32'(d), i);
        end
        chk("drain_empty", 32'(empty), 1);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
        chk("unf_set", 32'(underflow), 1);
`ifdef FIFO_LEVEL_FWFT_EN
        chk("unf_rdata", 32'(r_data), 0);
`else
        chk("unf_rdata", 32'(r_data), 8);
`endif
        step(1'b0, 1'b0, '0, 1'b1);
        chk("unf_clr", 32'(underflow), 0);
        chk("ovf_clr", 32'(overflow), 0);

        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, WL'(i), 1'b0);
        for (int i = 1; i <= 20; i++) begin
            pushpop(WL'(i + 8), d);
            chk("wrap_data", 32'(d), i);
            chk("wrap_count", 32'(count), 8);
        end
        chk("wrap_ovf", 32'(overflow), 0);
        for (int i = 21; i <= 28; i++) begin
            pop(d);
            chk("wrap_tail", 32'(d), i);
        end

        step(1'b1, 1'b1, 8'h5A, 1'b0);
        chk("rw_empty_count", 32'(count), 1);
        chk("rw_empty_unf", 32'(underflow), 1);
        pop(d);
        chk("rw_empty_data", 32'(d), 32'h5A);
        step(1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, WL'(i + 40), 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        do_reset();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_flags", 32'({overflow, underflow}), 0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        pop(d);
        chk("post_rst_data", 32'(d), 32'h33);

        for (int i = 0; i < 800; i++) begin
            if (i % 60 == 0) wprob = $urandom_range(20, 80);
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) >= wprob,
                     $urandom_range(0, 99) < wprob,
                     WL'($urandom),
                     $urandom_range(0, 99) < 5);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO, successor to the basic `fifo` buffer. Adds usable depth of exactly 2**ADDR_W words, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It optionally provides a first-word-fall-through read port. It sits between byte-stream producers and consumers (UART/ELM link, display pipeline) where back-pressure must be signalled before the buffer is full.

## Interface
- WORD_LEN, 8: data word width in bits.
- ADDR_W, 8: address width; depth DEPTH = 2**ADDR_W words, all usable.
- AF_TH, 2**ADDR_W-4: almost_full asserts when count >= AF_TH; legal range 1..DEPTH.
- AE_TH, 4: almost_empty asserts when count <= AE_TH; legal range 0..DEPTH-1.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low: state clears on a clk edge while reset=0.
- rd  in  1  read/pop request.
- wr  in  1  write/push request.
- w_data  in  WORD_LEN  write data, sampled when a write is accepted.
- clr_err  in  1  clears overflow and underflow at the next edge.
- r_data  out  WORD_LEN  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_TH.
- almost_full  out  1  count >= AF_TH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Storage: DEPTH x WORD_LEN array, write and read pointers of ADDR_W bits that wrap modulo DEPTH, and a count register of ADDR_W+1 bits. Full and empty are derived from count, not from pointer comparison.
- Write acceptance: wa = wr & (~full | rd). At full, a simultaneous rd+wr accepts both.
- Read acceptance: ra = rd & ~empty. At empty, a simultaneous rd+wr accepts only the write.
- Count update: +1 when wa&~ra, -1 when ra&~wa, unchanged otherwise. Count never leaves 0..DEPTH.
- Error flags:
  - overflow sets when wr&~wa.
  - underflow sets when rd&~ra.
  - Both hold until clr_err=1 or reset.
  - If clr_err and a new error event occur in the same cycle, the flag ends set (set wins).
- Rejected operations leave pointers, memory and count untouched.
- All status outputs (empty, full, almost_*) are decoded from the registered count. They are therefore glitch-free and reflect the state after the most recent edge.
- A full-DEPTH write sequence followed by DEPTH reads returns the words in write order, across pointer wrap-around.

## Timing
- Reset (reset=0 at an edge):
  - Pointers = 0, count = 0, r_data = 0, overflow = underflow = 0.
  - Status outputs: empty=1, full=0, almost_empty=1, almost_full = (AF_TH==0 ? 1 : 0).
  - Memory contents are not cleared.
  - Reset mid-stream discards all queued words.
  - Reset overrides rd, wr and clr_err in the same cycle.
- Write latency: a word accepted at edge k is readable from edge k+1.
- Status update: count and flags change at the same edge as the accepted operation.
- Standard read (macro absent):
  - r_data is registered. A read accepted at edge k loads the head word into r_data at edge k.
  - That word is valid from edge k until the next accepted read; one cycle of latency from rd.
  - Rejected reads leave r_data unchanged.
  - Simultaneous rd+wr at count 1 returns the old head, never the new word.
- Almost-flags: combinational compare on count. No hysteresis.

## Configuration
- FIFO_LEVEL_FWFT_EN defined: first-word-fall-through mode.
  - r_data continuously presents the head word mem[rd_ptr] whenever empty=0, and is 0 when empty=1.
  - rd acts as an acknowledge: an accepted read advances the pointer, and the next word appears after that edge.
  - A word written into an empty FIFO at edge k appears on r_data after edge k.
- FIFO_LEVEL_FWFT_EN undefined: standard registered read port as in Timing.
- Acceptance rules, count, flags and thresholds are identical in both modes.

## Test plan
Bench parameters: WORD_LEN=8, ADDR_W=3 (DEPTH=8), AF_TH=6, AE_TH=1. Run every scenario in both macro modes.
- Reset, then write 1..8 on consecutive cycles. Expect: count steps 1..8; almost_empty drops after the 2nd write; almost_full rises after the 6th; full=1 after the 8th; overflow=0.
- Write a 9th word (0xAA) at full with rd=0. Expect: overflow=1, count=8, no data change. Read 8 words. Expect 1..8 in order, with empty=1 after the 8th read.
- Hold rd=1 at empty for 3 cycles. Expect: underflow=1 and r_data unchanged (0 in FWFT mode). Pulse clr_err. Expect underflow=0 at the next edge.
- Fill to 8, then 20 cycles of rd=wr=1 with w_data=9..28. Expect: count stays 8, no overflow, and the output stream reads 1..20 after wrapping.
- At empty, assert rd=wr=1 with w_data=0x5A. Expect: write accepted, count=1, underflow=1. The next read returns 0x5A.
- Fill to 5, then drive reset=0 for one edge. Expect: count=0, empty=1, flags clear. A subsequent write/read of 0x33 returns 0x33.
